// File: rtl/opcode_pkg.sv
// ---------------------------------------------------------------------------
// opcode_pkg
//
// Shared definitions for the opcode fetch path: the fetch sequencer state
// type and the word/opcode geometry used by the controller, the stall
// watchdog and the shift-to-parallel register that sits beside them.
//
// Contents:
//   WORD_W         instruction word width (serial_in width of opcode_stp)
//   WORDS_PER_OP   words shifted per opcode
//   OPCODE_W       width of opcode_stp.parallel_out ({C,B,A})
//   WORD_CNT_W     width of the word_cnt status output
//   OP_COUNT_W     width of the completed-opcode counter
//   fetch_state_t  COLLECT (gathering words) / HOLD (opcode presented)
// ---------------------------------------------------------------------------
package opcode_pkg;

    localparam int WORD_W       = 32;
    localparam int WORDS_PER_OP = 3;
    localparam int OPCODE_W     = WORD_W * WORDS_PER_OP;
    localparam int WORD_CNT_W   = 2;
    localparam int OP_COUNT_W   = 16;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/opcode_fetch_wdt.sv
// ---------------------------------------------------------------------------
// opcode_fetch_wdt
//
// Stall watchdog for a partially collected opcode. It counts consecutive
// cycles in which the controller holds a partial opcode (armed) without
// accepting a word. On the TIMEOUT_CYCLES-th such cycle it raises abort
// combinationally, so the controller can drop the partial opcode at that
// same edge, and registers a one-cycle timeout_err pulse for the next cycle.
//
// Only instantiated when OPCODE_FETCH_TIMEOUT_EN is defined.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   armed        controller is in COLLECT with word_cnt > 0
//   accept       a word is accepted this cycle (wins over a timeout)
//   flush        partial opcode is being discarded this cycle
//   abort        combinational: drop the partial opcode at this edge
//   timeout_err  one-cycle pulse in the cycle after an abort
// ---------------------------------------------------------------------------
module opcode_fetch_wdt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic armed,
    input  logic accept,
    input  logic flush,
    output logic abort,
    output logic timeout_err
);
    import opcode_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             idle;

    assign idle  = armed & ~accept & ~flush;
    assign abort = idle & (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // The counter restarts whenever the partial opcode makes progress, is
    // discarded, or there is no partial opcode to guard.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (!idle || abort) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/opcode_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// opcode_fetch_ctrl
//
// Sequencer for the opcode shift-to-parallel register (opcode_stp). Words
// from the command FIFO are accepted over a valid/ready handshake and fed
// straight to opcode_stp as shifts; after WORDS_PER_OP shifts the complete
// opcode sits in opcode_stp.parallel_out and is offered to the decoder via
// opcode_valid/opcode_ready. The FIFO is stalled until the decoder takes it.
// opcode_stp itself lives beside this block, not inside it.
//
// Build option:
//   OPCODE_FETCH_TIMEOUT_EN  adds a stall watchdog (opcode_fetch_wdt) that
//                            aborts a partial opcode after TIMEOUT_CYCLES
//                            idle cycles and pulses timeout_err. Without it
//                            timeout_err is tied low.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   word_in           instruction word from the command FIFO
//   word_valid        word_in is valid
//   word_ready        word_in is accepted this cycle
//   stp_shift_enable  opcode_stp.shift_enable (same-edge capture)
//   stp_serial_in     opcode_stp.serial_in (zero when not shifting)
//   opcode_valid      parallel_out holds a complete opcode
//   opcode_ready      decoder consumes the opcode
//   flush             discard partial or held opcode
//   word_cnt          words shifted into the current opcode
//   op_count          completed opcode handshakes (wraps)
//   timeout_err       one-cycle pulse on partial-opcode abort
// ---------------------------------------------------------------------------
module opcode_fetch_ctrl #(
    parameter int WORD_W         = opcode_pkg::WORD_W,
    parameter int WORDS_PER_OP   = opcode_pkg::WORDS_PER_OP,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              stp_shift_enable,
    output logic [WORD_W-1:0] stp_serial_in,
    output logic              opcode_valid,
    input  logic              opcode_ready,
    input  logic              flush,
    output logic [1:0]        word_cnt,
    output logic [15:0]       op_count,
    output logic              timeout_err
);
    import opcode_pkg::*;

    fetch_state_t state;
    fetch_state_t state_next;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic [15:0]  ops_q;
    logic [15:0]  ops_d;
    logic         accept;
    logic         last_word;
    logic         abort;

    // Ready is gated by rst and flush so that no word is ever consumed in a
    // cycle whose effects the state register is about to throw away.
    assign word_ready       = (state == COLLECT) & ~flush & ~rst;
    assign accept           = word_valid & word_ready;
    assign stp_shift_enable = accept;
    assign stp_serial_in    = accept ? word_in : '0;
    assign opcode_valid     = (state == HOLD) & ~rst;
    assign last_word        = (cnt_q == 2'(WORDS_PER_OP - 1));
    assign word_cnt         = cnt_q;
    assign op_count         = ops_q;

`ifdef OPCODE_FETCH_TIMEOUT_EN
    opcode_fetch_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk         (clk),
        .rst         (rst),
        .armed       ((state == COLLECT) && (cnt_q != 2'd0)),
        .accept      (accept),
        .flush       (flush),
        .abort       (abort),
        .timeout_err (timeout_err)
    );
`else
    // TIMEOUT_CYCLES stays referenced so the parameter list is identical in
    // both builds; the expression is constant zero.
    assign abort       = 1'b0;
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            cnt_q <= '0;
            ops_q <= '0;
        end else begin
            state <= state_next;
            cnt_q <= cnt_d;
            ops_q <= ops_d;
        end
    end

    // In HOLD a completing handshake takes priority over flush, so a flush
    // that coincides with opcode_ready still counts the opcode.
    always_comb begin
        state_next = state;
        cnt_d      = cnt_q;
        ops_d      = ops_q;
        case (state)
            COLLECT: begin
                if (flush) begin
                    cnt_d = '0;
                end else if (accept) begin
                    if (last_word) begin
                        cnt_d      = '0;
                        state_next = HOLD;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (abort) begin
                    cnt_d = '0;
                end
            end
            HOLD: begin
                if (opcode_ready) begin
                    ops_d      = ops_q + 16'd1;
                    state_next = COLLECT;
                end else if (flush) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
                cnt_d      = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_opcode_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_opcode_fetch_ctrl
//
// Directed bench for opcode_fetch_ctrl with a behavioural opcode_stp beside
// it. Expected shifted words and expected opcodes are queued when stimulus is
// issued; a monitor pops and compares them whenever the DUT shifts or
// completes an opcode handshake. Per-cycle status outputs are checked against
// hand-computed values. Define OPCODE_FETCH_TIMEOUT_EN to add the watchdog
// vectors.
// ---------------------------------------------------------------------------
module tb_opcode_fetch_ctrl;
    import opcode_pkg::*;

    localparam int W  = WORD_W;
    localparam int OW = OPCODE_W;

    logic          tb_clk = 1'b0;
    logic          rst;
    logic [W-1:0]  word_in;
    logic          word_valid;
    logic          word_ready;
    logic          stp_shift_enable;
    logic [W-1:0]  stp_serial_in;
    logic          opcode_valid;
    logic          opcode_ready;
    logic          flush;
    logic [1:0]    word_cnt;
    logic [15:0]   op_count;
    logic          timeout_err;

    logic [OW-1:0] parallel_out;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [15:0]   cnt;
    } exp_op_t;

    logic [W-1:0]  exp_word_q[$];
    exp_op_t       exp_op_q[$];
    logic [W-1:0]  mon_word;
    exp_op_t       mon_op;

    int n_vec   = 0;
    int n_err   = 0;
    int exp_ops = 0;

    always #5 tb_clk = ~tb_clk;

    opcode_fetch_ctrl #(
        .WORD_W         (W),
        .WORDS_PER_OP   (WORDS_PER_OP),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk              (tb_clk),
        .rst              (rst),
        .word_in          (word_in),
        .word_valid       (word_valid),
        .word_ready       (word_ready),
        .stp_shift_enable (stp_shift_enable),
        .stp_serial_in    (stp_serial_in),
        .opcode_valid     (opcode_valid),
        .opcode_ready     (opcode_ready),
        .flush            (flush),
        .word_cnt         (word_cnt),
        .op_count         (op_count),
        .timeout_err      (timeout_err)
    );

    // Behavioural opcode_stp: first word ends up in the low slice ({C,B,A}).
    always @(posedge tb_clk) begin
        if (stp_shift_enable) begin
            parallel_out <= {stp_serial_in, parallel_out[OW-1:W]};
        end
    end

    task automatic checkOutput(input string name, input logic [OW-1:0] act,
                               input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the opcode expected at the next handshake, with the op_count
    // value it should carry at that moment.
    task automatic pushOp(input logic [OW-1:0] op);
        exp_op_t e;
        e.op  = op;
        e.cnt = 16'(exp_ops);
        exp_op_q.push_back(e);
    endtask

    // One clock cycle: drive inputs, check the pre-edge outputs at negedge,
    // then advance to just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] w,
                                 input logic ordy, input logic fl,
                                 input logic exp_shift, input logic exp_ov,
                                 input logic [1:0] exp_cnt, input logic exp_terr);
        word_valid   = v;
        word_in      = w;
        opcode_ready = ordy;
        flush        = fl;
        if (exp_shift) exp_word_q.push_back(w);
        @(negedge tb_clk);
        checkOutput("word_ready",   OW'(word_ready),       OW'(!exp_ov && !fl));
        checkOutput("shift_enable", OW'(stp_shift_enable), OW'(exp_shift));
        checkOutput("opcode_valid", OW'(opcode_valid),     OW'(exp_ov));
        checkOutput("word_cnt",     OW'(word_cnt),         OW'(exp_cnt));
        checkOutput("op_count",     OW'(op_count),         OW'(16'(exp_ops)));
        checkOutput("timeout_err",  OW'(timeout_err),      OW'(exp_terr));
        if (!exp_shift) checkOutput("serial_in_idle", OW'(stp_serial_in), OW'(0));
        if (exp_ov && ordy) exp_ops++;
        @(posedge tb_clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge tb_clk) begin
        if (stp_shift_enable) begin
            if (exp_word_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected_shift: got serial_in %0h, expected no shift at %0t",
                         stp_serial_in, $time);
            end else begin
                mon_word = exp_word_q.pop_front();
                checkOutput("shift_word", OW'(stp_serial_in), OW'(mon_word));
            end
        end
        if (opcode_valid && opcode_ready) begin
            if (exp_op_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected_handshake: got opcode %0h, expected none at %0t",
                         parallel_out, $time);
            end else begin
                mon_op = exp_op_q.pop_front();
                checkOutput("parallel_out",   parallel_out,    mon_op.op);
                checkOutput("op_count_at_hs", OW'(op_count),   OW'(mon_op.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        rst          = 1'b1;
        word_valid   = 1'b1;
        word_in      = 32'hFFFF_FFFF;
        opcode_ready = 1'b0;
        flush        = 1'b0;
        @(posedge tb_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge tb_clk);
            checkOutput("rst_word_ready",   OW'(word_ready),       OW'(0));
            checkOutput("rst_shift_enable", OW'(stp_shift_enable), OW'(0));
            checkOutput("rst_serial_in",    OW'(stp_serial_in),    OW'(0));
            checkOutput("rst_opcode_valid", OW'(opcode_valid),     OW'(0));
            checkOutput("rst_word_cnt",     OW'(word_cnt),         OW'(0));
            checkOutput("rst_op_count",     OW'(op_count),         OW'(0));
            checkOutput("rst_timeout_err",  OW'(timeout_err),      OW'(0));
            @(posedge tb_clk);
            #1;
        end
        rst = 1'b0;

        $display("[TB] back-to-back opcode");
        applyStimulus(1, 32'h1111_1111, 1, 0, 1, 0, 2'd0, 0);
        applyStimulus(1, 32'h2222_2222, 1, 0, 1, 0, 2'd1, 0);
        applyStimulus(1, 32'h3333_3333, 1, 0, 1, 0, 2'd2, 0);
        pushOp(96'h33333333_22222222_11111111);
        applyStimulus(1, 32'h0000_00A1, 1, 0, 0, 1, 2'd0, 0);
        applyStimulus(1, 32'h0000_00A1, 0, 0, 1, 0, 2'd0, 0);

        $display("[TB] decoder stall");
        applyStimulus(1, 32'h0000_00A2, 0, 0, 1, 0, 2'd1, 0);
        applyStimulus(1, 32'h0000_00A3, 0, 0, 1, 0, 2'd2, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'hBAD0_0000, 0, 0, 0, 1, 2'd0, 0);
        pushOp(96'h000000A3_000000A2_000000A1);
        applyStimulus(1, 32'hBAD0_0001, 1, 0, 0, 1, 2'd0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 2'd0, 0);

        $display("[TB] flush in COLLECT");
        applyStimulus(1, 32'hDEAD_0001, 0, 0, 1, 0, 2'd0, 0);
        applyStimulus(1, 32'hDEAD_0002, 0, 0, 1, 0, 2'd1, 0);
        applyStimulus(1, 32'hBAD0_0002, 0, 1, 0, 0, 2'd2, 0);
        applyStimulus(1, 32'h0000_0004, 0, 0, 1, 0, 2'd0, 0);
        applyStimulus(1, 32'h0000_0005, 0, 0, 1, 0, 2'd1, 0);
        applyStimulus(1, 32'h0000_0006, 0, 0, 1, 0, 2'd2, 0);
        pushOp(96'h00000006_00000005_00000004);
        applyStimulus(0, 32'h0, 1, 0, 0, 1, 2'd0, 0);

        $display("[TB] gapped valid, flush with ready in HOLD");
        applyStimulus(1, 32'h0000_0007, 0, 0, 1, 0, 2'd0, 0);
        applyStimulus(0, 32'h0000_0077, 0, 0, 0, 0, 2'd1, 0);
        applyStimulus(0, 32'h0000_0077, 0, 0, 0, 0, 2'd1, 0);
        applyStimulus(1, 32'h0000_0008, 0, 0, 1, 0, 2'd1, 0);
        applyStimulus(0, 32'h0000_0088, 0, 0, 0, 0, 2'd2, 0);
        applyStimulus(1, 32'h0000_0009, 0, 0, 1, 0, 2'd2, 0);
        pushOp(96'h00000009_00000008_00000007);
        applyStimulus(0, 32'h0, 1, 1, 0, 1, 2'd0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 2'd0, 0);

        $display("[TB] flush in HOLD drops opcode");
        applyStimulus(1, 32'h0000_00B1, 0, 0, 1, 0, 2'd0, 0);
        applyStimulus(1, 32'h0000_00B2, 0, 0, 1, 0, 2'd1, 0);
        applyStimulus(1, 32'h0000_00B3, 0, 0, 1, 0, 2'd2, 0);
        applyStimulus(1, 32'hBAD0_0003, 0, 1, 0, 1, 2'd0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 2'd0, 0);

`ifdef OPCODE_FETCH_TIMEOUT_EN
        $display("[TB] stall timeout");
        applyStimulus(1, 32'h0000_00C1, 0, 0, 1, 0, 2'd0, 0);
        for (int i = 0; i < 64; i++) applyStimulus(0, 32'h0, 0, 0, 0, 0, 2'd1, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 2'd0, 1);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 2'd0, 0);

        $display("[TB] accept on last idle cycle wins");
        applyStimulus(1, 32'h0000_00C2, 0, 0, 1, 0, 2'd0, 0);
        for (int i = 0; i < 63; i++) applyStimulus(0, 32'h0, 0, 0, 0, 0, 2'd1, 0);
        applyStimulus(1, 32'h0000_00C3, 0, 0, 1, 0, 2'd1, 0);
        applyStimulus(1, 32'h0000_00C4, 0, 0, 1, 0, 2'd2, 0);
        pushOp(96'h000000C4_000000C3_000000C2);
        applyStimulus(0, 32'h0, 1, 0, 0, 1, 2'd0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 2'd0, 0);
`endif

        @(negedge tb_clk);
        checkOutput("word_q_drained", OW'(exp_word_q.size()), OW'(0));
        checkOutput("op_q_drained",   OW'(exp_op_q.size()),   OW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/opcode_fetch_ctrl.md
# opcode_fetch_ctrl

Sequencer for the opcode shift-to-parallel register (`opcode_stp`).
- Accepts 32-bit instruction words from the command FIFO over a valid/ready handshake.
- Drives `opcode_stp`'s `shift_enable`/`serial_in` so that exactly WORDS_PER_OP words are shifted per opcode.
- Tells the opcode decoder, via `opcode_valid`/`opcode_ready`, when `opcode_stp.parallel_out` holds a complete opcode ({C,B,A}). It stalls the FIFO until the decoder consumes the opcode.

## Interface
Parameters:
- WORD_W, 32, instruction word width (matches `opcode_stp` `serial_in`)
- WORDS_PER_OP, 3, words per opcode (>=2)
- TIMEOUT_CYCLES, 64, idle-cycle limit for a partial opcode (used only with the timeout feature)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous active-high reset
- `word_in`  in  WORD_W  instruction word from command FIFO
- `word_valid`  in  1  `word_in` valid
- `word_ready`  out  1  controller accepts `word_in` this cycle
- `stp_shift_enable`  out  1  to `opcode_stp.shift_enable`
- `stp_serial_in`  out  WORD_W  to `opcode_stp.serial_in`
- `opcode_valid`  out  1  `opcode_stp.parallel_out` holds a complete opcode
- `opcode_ready`  in  1  decoder consumes opcode
- `flush`  in  1  discard partial/held opcode
- `word_cnt`  out  2  words shifted into current opcode (0..WORDS_PER_OP-1)
- `op_count`  out  16  completed opcode handshakes, wraps 0xFFFF->0
- `timeout_err`  out  1  one-cycle pulse on partial-opcode abort

## Operation
- FSM states:
  - COLLECT: reset state, `word_cnt`=0.
  - HOLD.
- Accept condition: `accept = word_valid & word_ready`.
- `word_ready` = (state==COLLECT) & ~`flush` & ~`rst`.
- `stp_shift_enable` = `accept`. This is combinational; `opcode_stp` captures at the same rising edge.
- `stp_serial_in` = `word_in` when `accept`, else 0.
- COLLECT:
  - On `accept` with `word_cnt`<WORDS_PER_OP-1: `word_cnt`+1.
  - On `accept` with `word_cnt`==WORDS_PER_OP-1: `word_cnt`<=0, go to HOLD.
- HOLD:
  - `opcode_valid`=1 (Moore), `word_ready`=0.
  - On `opcode_ready`: `op_count`+1, go to COLLECT.
- `flush` in COLLECT: `word_cnt`<=0, no accept that cycle. Words already shifted remain in `opcode_stp` and are overwritten by later shifts.
- `flush` in HOLD without `opcode_ready`: drop the opcode, go to COLLECT, `op_count` unchanged.
- `flush` and `opcode_ready` together in HOLD: the handshake completes (`op_count`+1), then go to COLLECT.
- `word_valid` while in HOLD is ignored; no shift occurs.
- Reset values:
  - `word_ready`=0, `stp_shift_enable`=0, `stp_serial_in`=0, `opcode_valid`=0.
  - `word_cnt`=0, `op_count`=0, `timeout_err`=0.
- Reset mid-opcode discards the partial opcode.

## Timing
- Final word accepted at edge E (the last STP shift) → `opcode_valid` high from E until the handshake edge.
- `parallel_out` is stable while `opcode_valid`=1.
- Minimum opcode period is WORDS_PER_OP+1 cycles. HOLD always costs at least one cycle, during which `word_ready`=0.
- The first word can be accepted in the first cycle after `rst` deasserts.

## Configuration
- Macro: `OPCODE_FETCH_TIMEOUT_EN`.
- With `OPCODE_FETCH_TIMEOUT_EN` defined:
  - A stall counter increments each COLLECT cycle with `word_cnt`>0 and no `accept`. It clears on `accept`, `flush` and `rst`.
  - On the TIMEOUT_CYCLES-th consecutive idle cycle: `word_cnt`<=0, counter<=0, and `timeout_err`=1 for exactly the next cycle.
  - An `accept` in that same cycle wins: no abort.
- Without the macro: the counter is not built and `timeout_err` is tied to 0. The port list is unchanged.

## Structure
- Shared package `opcode_pkg`:
  - State enum `fetch_state_t` (COLLECT, HOLD).
  - Constants WORD_W=32, WORDS_PER_OP=3, OPCODE_W=WORD_W*WORDS_PER_OP=96.
- Sub-module `opcode_fetch_wdt`: the stall counter and `timeout_err` pulse generator, instantiated only under `OPCODE_FETCH_TIMEOUT_EN`.
- `opcode_stp` is instantiated alongside the controller, not inside it. The decoder reads `opcode_stp.parallel_out` directly.

## Test plan
- Reset: `rst`=1 for 2 cycles with `word_valid`=1 → all outputs 0 and no shift; in the first cycle after release, `word_ready`=1.
- Back-to-back A=0x11111111, B=0x22222222, C=0x33333333 with `opcode_ready`=1 → `stp_shift_enable` high 3 consecutive cycles; `opcode_valid` high 1 cycle; `parallel_out`=0x333333332222222211111111; `op_count`=1; next word accepted 2 cycles after C.
- `opcode_ready`=0 for 5 cycles while `word_valid`=1 → `opcode_valid` held 5 cycles, `word_ready`=0, no shifts; releasing `opcode_ready` → `op_count` increments once.
- `flush` after 2 words, then D/E/F=4/5/6 → `word_cnt` 2→0; opcode completes after F with `parallel_out`={6,5,4}.
- `word_valid` toggled 1,0,0,1,0,1 → shifts only on the 3 valid cycles; `opcode_valid` after the third.
- With the macro: 1 word then 64 idle cycles → `timeout_err` pulses one cycle, `word_cnt`=0; a word on the 64th idle cycle → no abort.
